div_rem_unit: RTL

Multi-cycle signed divide/remainder engine that sits downstream of the control unit, beside the single-cycle ALU. It consumes alu_control codes 0100 (div) and 0101 (rem) together with the register-file operands. While it computes, it raises stall so the PC and register write-back hold. It delivers a RISC-V-compliant 32-bit quotient or remainder, which the core muxes over the ALU result.

---
 rtl/riscv_pkg.sv | 33 +++
 rtl/div_rem_unit_if.sv | 16 +
 rtl/div_rem_unit_step.sv | 19 +
 rtl/div_rem_unit.sv | 112 +++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared core constants: ALU control codes, major opcodes and the divider FSM encoding.
package riscv_pkg;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_DIV = 4'b0100;
  localparam logic [3:0] ALU_REM = 4'b0101;
  localparam logic [3:0] ALU_XOR = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SLL = 4'b1000;
  localparam logic [3:0] ALU_SRL = 4'b1001;
  localparam logic [3:0] ALU_SRA = 4'b1010;
  localparam logic [3:0] ALU_GE  = 4'b1011;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_rem_unit_if.sv
// Core-side interface of the divide/remainder unit: request operands in, result and pipeline control out.
interface div_rem_unit_if #(parameter int XLEN = 32);
  logic            inst_valid;
  logic [3:0]      alu_control;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] result;
  logic            done;
  logic            stall;
  logic            busy;

  modport master (output inst_valid, alu_control, op_a, op_b,
                  input  result, done, stall, busy);
  modport slave  (input  inst_valid, alu_control, op_a, op_b,
                  output result, done, stall, busy);
endinterface

// File: rtl/div_rem_unit_step.sv
// One restoring-division step on magnitudes: shift in a dividend bit, subtract divisor if it fits.
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic            dividend_bit_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] rem_o,
  output logic            q_bit_o
);
  logic [XLEN:0]   trial;
  logic [XLEN-1:0] diff;

  // Extra top bit keeps the compare exact when the divisor magnitude is 2^(XLEN-1).
  assign trial   = {rem_i, dividend_bit_i};
  assign q_bit_o = (trial >= {1'b0, divisor_i});
  assign diff    = trial[XLEN-1:0] - divisor_i;
  assign rem_o   = q_bit_o ? diff : trial[XLEN-1:0];
endmodule

// File: rtl/div_rem_unit.sv
// Multi-cycle signed div/rem engine: fast paths for divide-by-zero and overflow, otherwise XLEN restoring steps.
module div_rem_unit
  import riscv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic          clk,
  input  logic          rst,
  div_rem_unit_if.slave bus
);
  div_state_t      state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0] dvd_q, dvs_q, rem_q, result_q, result_d;
  logic            q_neg_q, r_neg_q, is_rem_q, done_q, busy_q;

  logic            req, is_rem_in, div_zero, ovf, fast;
  logic [XLEN-1:0] abs_a, abs_b, step_rem, quot_fin;
  logic            step_q;

  assign is_rem_in = (bus.alu_control == ALU_REM);
  assign req       = bus.inst_valid & ((bus.alu_control == ALU_DIV) | is_rem_in);
  assign div_zero  = (bus.op_b == '0);
  assign ovf       = (bus.op_a == {1'b1, {(XLEN-1){1'b0}}}) && (bus.op_b == '1);
  assign fast      = div_zero | ovf;
  assign abs_a     = bus.op_a[XLEN-1] ? -bus.op_a : bus.op_a;
  assign abs_b     = bus.op_b[XLEN-1] ? -bus.op_b : bus.op_b;

  div_step #(.XLEN(XLEN)) u_step (
    .rem_i          (rem_q),
    .dividend_bit_i (dvd_q[XLEN-1]),
    .divisor_i      (dvs_q),
    .rem_o          (step_rem),
    .q_bit_o        (step_q)
  );

  // Quotient bits shift into the low end of the dividend register as its MSBs are consumed.
  assign quot_fin = {dvd_q[XLEN-2:0], step_q};

  always_comb begin
    result_d = result_q;
    if (state_q == ST_IDLE) begin
      if (div_zero)  result_d = is_rem_in ? bus.op_a : '1;
      else if (ovf)  result_d = is_rem_in ? '0 : bus.op_a;
    end else if (state_q == ST_RUN) begin
      if (is_rem_q)  result_d = r_neg_q ? -step_rem : step_rem;
      else           result_d = q_neg_q ? -quot_fin : quot_fin;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      result_q <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      is_rem_q <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req) begin
            if (fast) begin
              result_q <= result_d;
              done_q   <= 1'b1;
              state_q  <= ST_DONE;
            end else begin
              dvd_q    <= abs_a;
              dvs_q    <= abs_b;
              rem_q    <= '0;
              q_neg_q  <= bus.op_a[XLEN-1] ^ bus.op_b[XLEN-1];
              r_neg_q  <= bus.op_a[XLEN-1];
              is_rem_q <= is_rem_in;
              cnt_q    <= CNT_W'(XLEN);
              busy_q   <= 1'b1;
              state_q  <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (!req) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            rem_q <= step_rem;
            dvd_q <= quot_fin;
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
              result_q <= result_d;
              done_q   <= 1'b1;
              busy_q   <= 1'b0;
              state_q  <= ST_DONE;
            end
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.stall  = req & (state_q != ST_DONE);
  assign bus.result = result_q;
  assign bus.done   = done_q;
  assign bus.busy   = busy_q;
endmodule
